pipe_stage_hs: RTL
==================

// Module: pipe_stage_hs
// PURPOSE
// Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
// It is the successor of the fixed-field decode->execute latch. Callers pack decoded control fields (ALU ctrl, imm, selects, jump and lam fields) into one payload bus.
// The handshake replaces the bare enable, so a stall propagates backward cycle-by-cycle without a combinational ready path.
// Sits between the decode and execute stages; the same block is reused for the other inter-stage boundaries.
// PARAMETERS
// DATA_W   74  payload width in bits (decode->execute packing: 32+1+10+6+5+6+3+1+9+1)
// SKID_EN  1   1: 2-entry skid, registered in_ready; 0: single register, combinational in_ready
// CNT_W    16  width of the accepted-transfer counter
// PORTS
// clk        in   1       clock, all state on rising edge
// reset      in   1       asynchronous, active-high
// flush      in   1       sync kill: discard all held entries (branch mispredict / jump taken)
// in_valid   in   1       upstream payload valid
// in_ready   out  1       stage can accept payload this cycle
// in_data    in   DATA_W  upstream payload
// out_valid  out  1       payload available to downstream
// out_ready  in   1       downstream accepts payload this cycle
// out_data   out  DATA_W  payload presented downstream
// occupancy  out  2       entries held (0..2; max 1 when SKID_EN=0)
// xfer_cnt   out  CNT_W   count of accepted input transfers, wraps modulo 2^CNT_W
// BEHAVIOUR
// - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
// - Reset (async): state EMPTY, out_valid=0, out_data=0, skid reg=0, occupancy=0, xfer_cnt=0, in_ready=1.
// - FSM when SKID_EN=1. States: EMPTY (occ 0), ONE (main full), TWO (main+skid full). out_valid = (state!=EMPTY).
//   EMPTY: in_fire -> ONE, main<=in_data.
//   ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire only -> TWO, skid<=in_data. out_fire only -> EMPTY. Neither -> hold.
//   TWO: in_ready=0, so no in_fire. out_fire -> ONE, main<=skid. Otherwise hold.
//   in_ready is a register: 1 in EMPTY/ONE, 0 in TWO. It is never a combinational function of out_ready.
// - SKID_EN=0: states EMPTY/ONE only. in_ready = ~out_valid | out_ready (combinational). in_fire loads main.
// - Latency: in_fire at cycle N -> out_valid=1 with that data at N+1 when the stage was empty. Order is strict FIFO.
// - Stability: while out_valid & ~out_ready, out_data and out_valid do not change.
// - Flush (priority over everything except reset):
//   - next state EMPTY, out_valid=0 at N+1, main and skid cleared to 0, in_ready=1 at N+1.
//   - A same-cycle in_fire is discarded but still counted in xfer_cnt.
//   - A same-cycle out_fire is still valid for downstream.
// - xfer_cnt increments by 1 on every in_fire. 2^CNT_W-1 wraps to 0. It is not cleared by flush.
// - Reset mid-transfer: all entries lost, outputs return to reset values immediately.
// - out_data with out_valid=0 is don't-care for consumers, but is 0 after reset/flush (bench checks this).
// TESTING
// 1. Reset, then in_valid=1, in_data=0x1234, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0x1234; occupancy=1.
// 2. Stream A,B,C with out_ready held 1 -> one word/cycle, order A,B,C, in_ready stays 1, xfer_cnt=3.
// 3. out_ready=0, send A then B -> occupancy=2, in_ready=0, out_data=A held. out_ready=1 -> A then B out, in_ready=1 one cycle after A drains.
// 4. occupancy=2, assert flush with in_valid=1 (D) -> next cycle out_valid=0, occupancy=0, out_data=0, D never appears, xfer_cnt includes D.
// 5. Preload xfer_cnt to 0xFFFF (CNT_W=16) via 65535 transfers, one more in_fire -> xfer_cnt=0.
// 6. SKID_EN=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle. out_ready=1 with in_valid=1 (E) -> E out next cycle, no bubble.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a free-running accepted-transfer counter.
module pipe_stage_hs #(
  parameter int unsigned DATA_W  = 74,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [1:0]          r_occ;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_out_fire;

  // Skid mode keeps in_ready registered; bypass mode lets a draining output admit new data.
  generate
    if (SKID_EN) begin : g_skid_ready
      assign w_in_ready = r_in_ready;
    end else begin : g_comb_ready
      assign w_in_ready = ~r_out_valid | out_ready;
    end
  endgenerate

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;
  assign xfer_cnt  = r_cnt;

  // State, payload and status registers; flush overrides every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occ       <= 2'd0;
      r_cnt       <= '0;
    end else begin
      if (w_in_fire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (flush) begin
        r_state     <= ST_EMPTY;
        r_main      <= '0;
        r_skid      <= '0;
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
        r_occ       <= 2'd0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              r_state     <= ST_ONE;
              r_main      <= in_data;
              r_out_valid <= 1'b1;
              r_occ       <= 2'd1;
            end
          end
          ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main <= in_data;
            end else if (w_in_fire && SKID_EN) begin
              r_state    <= ST_TWO;
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
              r_occ      <= 2'd2;
            end else if (w_out_fire) begin
              r_state     <= ST_EMPTY;
              r_out_valid <= 1'b0;
              r_occ       <= 2'd0;
            end
          end
          ST_TWO: begin
            if (w_out_fire) begin
              r_state    <= ST_ONE;
              r_main     <= r_skid;
              r_in_ready <= 1'b1;
              r_occ      <= 2'd1;
            end
          end
          default: begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule
